// File: rtl/sme_pkg.sv
// sme_pkg: shared definitions for the sme_multi string-match engine.
//   - ASCII constants for the meta-characters and the word separator
//   - sme_state_t: control FSM states
//   - fold_case(): ASCII upper-case to lower-case fold used by compares
package sme_pkg;

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_SPACE  = 8'h20;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_START,
    ST_CMP,
    ST_HIT,
    ST_REPORT,
    ST_NEXT,
    ST_END
  } sme_state_t;

  function automatic logic [7:0] fold_case(input logic [7:0] c);
    if (c >= 8'h41 && c <= 8'h5A) return c | 8'h20;
    return c;
  endfunction

endpackage

// File: rtl/sme_multi_if.sv
// sme_multi_if: character stream and result bus of sme_multi.
//   master (stream source / result sink):
//     out chardata[7:0], isstring, ispattern, icase, find_all
//     in  ready, valid, match, match_index[IW-1:0], done, match_cnt[IW:0], ovf
//   slave (sme_multi): the same signals with directions reversed.
// STR_MAX must equal the STR_MAX of the attached sme_multi.
interface sme_multi_if #(
  parameter int STR_MAX = 32
);
  localparam int IW = $clog2(STR_MAX);

  logic [7:0]  chardata;
  logic        isstring;
  logic        ispattern;
  logic        icase;
  logic        find_all;
  logic        ready;
  logic        valid;
  logic        match;
  logic [IW-1:0] match_index;
  logic        done;
  logic [IW:0] match_cnt;
  logic        ovf;

  modport master (
    output chardata, isstring, ispattern, icase, find_all,
    input  ready, valid, match, match_index, done, match_cnt, ovf
  );

  modport slave (
    input  chardata, isstring, ispattern, icase, find_all,
    output ready, valid, match, match_index, done, match_cnt, ovf
  );

endinterface

// File: rtl/sme_char_cmp.sv
// sme_char_cmp: single-character compare of a string character against a
// pattern symbol.
//   s_char[7:0] in : string character
//   p_char[7:0] in : pattern symbol ('.' matches anything)
//   icase       in : fold A-Z to a-z on both sides before comparing
//   hit         out: symbol accepts the character
module sme_char_cmp
  import sme_pkg::*;
(
  input  logic [7:0] s_char,
  input  logic [7:0] p_char,
  input  logic       icase,
  output logic       hit
);

  always_comb begin
    hit = 1'b0;
    if (p_char == CH_DOT) begin
      hit = 1'b1;
    end else if (icase) begin
      hit = (fold_case(s_char) == fold_case(p_char));
    end else begin
      hit = (s_char == p_char);
    end
  end

endmodule

// File: rtl/sme_multi.sv
// sme_multi: buffered string-match engine with ^ $ . meta-characters,
// optional case-insensitive compare and find-all reporting.
//   clk   in : rising-edge clock
//   reset in : synchronous, active-low
//   bus   slave modport of sme_multi_if:
//     chardata/isstring/ispattern load the buffers while ready is high,
//     icase/find_all are captured when the search starts,
//     valid pulses carry match/match_index; done marks the last pulse of a
//     search and qualifies match_cnt; ovf flags dropped load characters.
module sme_multi
  import sme_pkg::*;
#(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  sme_multi_if.slave bus
);

  localparam int IW = $clog2(STR_MAX);
  localparam int PW = $clog2(PAT_MAX);
  localparam logic [IW:0] SLEN_FULL = (IW+1)'(STR_MAX);
  localparam logic [PW:0] PLEN_FULL = (PW+1)'(PAT_MAX);

  sme_state_t    state_q;
  logic [7:0]    str_q [STR_MAX];
  logic [7:0]    pat_q [PAT_MAX];
  logic [IW:0]   slen_q;
  logic [PW:0]   plen_q;
  logic          str_seen_q;   // a string char arrived in this load
  logic          loading_q;    // any strobe arrived in this load
  logic [IW-1:0] s_q;          // current start position
  logic [IW:0]   c_q;          // string cursor
  logic [PW-1:0] k_q;          // pattern symbol index
  logic          icase_q;
  logic          fa_q;
  logic [IW:0]   cnt_q;

  logic          ready_q;
  logic          valid_q;
  logic          match_q;
  logic [IW-1:0] idx_q;
  logic          done_q;
  logic [IW:0]   mcnt_q;
  logic          ovf_q;

  // Pattern shape, derived from the buffer while a search is running.
  logic          lead;
  logic          trail;
  logic [PW-1:0] plast;
  logic          is_last;
  logic          anchor_ok;
  logic          dollar_ok;
  logic          sym_ok;
  logic          last_s;
  logic          cmp_hit;
  logic [7:0]    s_char;
  logic [IW:0]   cnt_inc;

  assign plast  = plen_q[PW-1:0] - 1'b1;
  assign s_char = str_q[c_q[IW-1:0]];

  always_comb begin
    lead      = (pat_q[0] == CH_CARET);
    // A lone '^' is the leading anchor, never a trailing '$'.
    trail     = (pat_q[plast] == CH_DOLLAR) && !(lead && plen_q == (PW+1)'(1));
    is_last   = (k_q == plast);
    anchor_ok = !lead || (s_q == '0) || (str_q[IW'(s_q - 1'b1)] == CH_SPACE);
    dollar_ok = (c_q == slen_q) || (s_char == CH_SPACE);
    sym_ok    = (is_last && trail) ? dollar_ok : ((c_q != slen_q) && cmp_hit);
    last_s    = (({1'b0, s_q} + 1'b1) == slen_q);
    cnt_inc   = (cnt_q == SLEN_FULL) ? cnt_q : cnt_q + 1'b1;
  end

  sme_char_cmp u_cmp (
    .s_char (s_char),
    .p_char (pat_q[k_q]),
    .icase  (icase_q),
    .hit    (cmp_hit)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_LOAD;
      slen_q     <= '0;
      plen_q     <= '0;
      str_seen_q <= 1'b0;
      loading_q  <= 1'b0;
      s_q        <= '0;
      c_q        <= '0;
      k_q        <= '0;
      icase_q    <= 1'b0;
      fa_q       <= 1'b0;
      cnt_q      <= '0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      match_q    <= 1'b0;
      idx_q      <= '0;
      done_q     <= 1'b0;
      mcnt_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      match_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          if (bus.isstring) begin
            loading_q  <= 1'b1;
            str_seen_q <= 1'b1;
            if (!loading_q) ovf_q <= 1'b0;
            // First string char of a load replaces the retained string.
            if (!str_seen_q) begin
              str_q[0] <= bus.chardata;
              slen_q   <= (IW+1)'(1);
            end else if (slen_q != SLEN_FULL) begin
              str_q[slen_q[IW-1:0]] <= bus.chardata;
              slen_q <= slen_q + 1'b1;
            end else begin
              ovf_q <= 1'b1;
            end
          end else if (bus.ispattern) begin
            loading_q <= 1'b1;
            if (!loading_q) ovf_q <= 1'b0;
            if (plen_q != PLEN_FULL) begin
              pat_q[plen_q[PW-1:0]] <= bus.chardata;
              plen_q <= plen_q + 1'b1;
            end else begin
              ovf_q <= 1'b1;
            end
          end else if (plen_q != '0) begin
            state_q    <= ST_START;
            ready_q    <= 1'b0;
            icase_q    <= bus.icase;
            fa_q       <= bus.find_all;
            s_q        <= '0;
            cnt_q      <= '0;
            loading_q  <= 1'b0;
            str_seen_q <= 1'b0;
          end
        end

        ST_START: begin
          if (slen_q == '0) begin
            state_q <= ST_END;
            valid_q <= 1'b1;
            done_q  <= 1'b1;
            idx_q   <= '0;
            mcnt_q  <= '0;
          end else if (!anchor_ok) begin
            state_q <= ST_NEXT;
          end else if (lead && plen_q == (PW+1)'(1)) begin
            state_q <= ST_HIT;
          end else begin
            state_q <= ST_CMP;
            k_q     <= lead ? PW'(1) : '0;
            c_q     <= {1'b0, s_q};
          end
        end

        ST_CMP: begin
          if (!sym_ok) begin
            state_q <= ST_NEXT;
          end else if (is_last) begin
            state_q <= ST_HIT;
          end else begin
            k_q <= k_q + 1'b1;
            c_q <= c_q + 1'b1;
          end
        end

        ST_HIT: begin
          state_q <= ST_REPORT;
          cnt_q   <= cnt_inc;
          valid_q <= 1'b1;
          match_q <= 1'b1;
          idx_q   <= s_q;
          done_q  <= !fa_q;
          mcnt_q  <= fa_q ? cnt_inc : (IW+1)'(1);
        end

        ST_REPORT: begin
          if (fa_q) begin
            state_q <= ST_NEXT;
          end else begin
            state_q <= ST_LOAD;
            ready_q <= 1'b1;
            plen_q  <= '0;
          end
        end

        ST_NEXT: begin
          if (last_s) begin
            state_q <= ST_END;
            valid_q <= 1'b1;
            done_q  <= 1'b1;
            idx_q   <= '0;
            mcnt_q  <= cnt_q;
          end else begin
            state_q <= ST_START;
            s_q     <= s_q + 1'b1;
          end
        end

        ST_END: begin
          state_q <= ST_LOAD;
          ready_q <= 1'b1;
          plen_q  <= '0;
        end

        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign bus.ready       = ready_q;
  assign bus.valid       = valid_q;
  assign bus.match       = match_q;
  assign bus.match_index = idx_q;
  assign bus.done        = done_q;
  assign bus.match_cnt   = mcnt_q;
  assign bus.ovf         = ovf_q;

endmodule
